pixel_write_arbiter: RTL
========================

PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2: number of pixel-writer channels, 1..8.
REQ-002 Parameter X_W, default 8: x coordinate width.
REQ-003 Parameter Y_W, default 7: y coordinate width.
REQ-004 Parameter COLOUR_W, default 18: colour width (3 channels x 6 bits).
REQ-005 Parameter X_MAX, default 159: last valid x.
REQ-006 Parameter Y_MAX, default 119: last valid y.
REQ-007 Port clock, input, 1: sole clock; all logic on rising edge.
REQ-008 Port resetn, input, 1: reset, synchronous and active-low.
REQ-009 Port req_valid, input, NUM_CH: per-channel write request.
REQ-010 Port req_ready, output, NUM_CH: per-channel grant; transfer when valid and ready are both high.
REQ-011 Port req_x, input, NUM_CH*X_W: packed x; channel i in bits [i*X_W +: X_W].
REQ-012 Port req_y, input, NUM_CH*Y_W: packed y, same packing.
REQ-013 Port req_colour, input, NUM_CH*COLOUR_W: packed colour, same packing.
REQ-014 Port clear_start, input, 1: single-cycle request for a full-screen fill.
REQ-015 Port clear_colour, input, COLOUR_W: fill colour, sampled with clear_start.
REQ-016 Port clear_busy, output, 1: high while a fill is in progress.
REQ-017 Port clear_done, output, 1: one-cycle pulse when a fill completes.
REQ-018 Port drop, output, 1: one-cycle pulse when an out-of-range request is discarded.
REQ-019 Ports vga_x (X_W), vga_y (Y_W), vga_colour (COLOUR_W), vga_write (1), outputs: registered pixel-write port to the VGA adapter.

Function
REQ-020 The FSM SHALL have exactly two states: IDLE (arbitrate channels) and CLEAR (fill sweep).
REQ-021 In IDLE, at most one req_ready bit SHALL be high, combinationally.
- It goes to the first channel with req_valid high, searching round-robin from rr_ptr.
REQ-022 On a transfer from channel i, rr_ptr SHALL load (i+1) mod NUM_CH; with no transfer, rr_ptr holds.
REQ-023 An in-range transfer (x<=X_MAX and y<=Y_MAX) SHALL give vga_write=1 on the next cycle.
- vga_x, vga_y and vga_colour carry that channel's captured values.
- Latency is exactly 1 cycle; throughput is one pixel per cycle.
REQ-024 An out-of-range transfer SHALL still be accepted.
- It produces vga_write=0 and drop=1 on the next cycle.
REQ-025 With no transfer, vga_write SHALL be 0 on the next cycle; vga_x, vga_y and vga_colour hold their last values.
REQ-026 clear_start=1 in IDLE SHALL force req_ready to all zeros that cycle.
- It latches clear_colour and enters CLEAR next cycle.
- It takes priority over any req_valid in the same cycle.
REQ-027 In CLEAR, req_ready SHALL be all zeros and clear_busy=1.
- One pixel is written per cycle, raster order: x 0..X_MAX inner loop, y 0..Y_MAX outer loop.
- Each pixel uses the latched colour and vga_write=1.
REQ-028 The fill SHALL take exactly (X_MAX+1)*(Y_MAX+1) vga_write cycles; default 19200.
REQ-029 After the cycle in which pixel (X_MAX,Y_MAX) is presented, the FSM SHALL return to IDLE.
- clear_done=1 for one cycle and clear_busy=0 in that first IDLE cycle.
REQ-030 clear_start while in CLEAR SHALL be ignored; no restart, colour unchanged.
REQ-031 Sweep counters SHALL wrap x to 0 and increment y only at x=X_MAX; no coordinate beyond the maxima is ever output.

Reset
REQ-032 While resetn=0 at a clock edge, all of the following SHALL be forced on that edge:
- state=IDLE, rr_ptr=0, sweep counters 0, latched colour 0;
- vga_x, vga_y, vga_colour and vga_write all 0;
- clear_busy, clear_done and drop all 0; req_ready all 0.
REQ-033 Reset asserted mid-fill SHALL abort the fill without a clear_done pulse.
REQ-034 The first transfer after reset release SHALL be possible in the first cycle resetn=1.

Structure
REQ-035 Package doom58_pkg SHALL hold:
- screen constants SCREEN_W=160, SCREEN_H=120, COLOUR_W=18;
- the FSM state enum {IDLE, CLEAR}.
REQ-036 Round-robin grant logic SHALL be a sub-module rr_arbiter (parameter N; inputs req, ptr; output one-hot grant).
REQ-037 The top instantiates one pixel_write_arbiter between the game controller and HUD writers and the VGA adapter, with NUM_CH=2.

Verification
REQ-038 Single write: channel 0 presents (10,20,0x3FFFF) -> ready0=1; next cycle vga_write=1 at (10,20,0x3FFFF).
REQ-039 Fairness: both channels valid continuously for 6 cycles -> grants ch0,ch1,ch0,ch1,ch0,ch1; six consecutive vga_write pulses.
REQ-040 Out of range: channel 1 presents (160,5) -> accepted; next cycle vga_write=0, drop=1.
REQ-041 Fill: clear_start with colour 0x00FC0 -> 19200 consecutive writes from (0,0) to (159,119).
- clear_done pulses exactly once; req_ready stays 0 throughout.
REQ-042 Collision: clear_start and req_valid[0] in the same cycle -> no grant that cycle; channel 0 is served first after clear_done.
REQ-043 Reset at fill pixel 5000 -> all outputs 0 next cycle; no clear_done; normal arbitration resumes after release.

Source files
------------

// File: rtl/doom58_pkg.sv
// -----------------------------------------------------------------------------
// doom58_pkg
// Shared constants and types for the pixel pipeline in front of the VGA
// adapter.
//   SCREEN_W / SCREEN_H : visible raster size in pixels
//   COLOUR_W            : colour word width (3 channels x 6 bits)
//   state_t             : pixel_write_arbiter FSM states
// -----------------------------------------------------------------------------
package doom58_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 18;

    // IDLE arbitrates the writer channels, CLEAR sweeps the whole screen.
    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant. The search for a requester starts
// at index ptr and wraps around, so the channel at ptr has top priority.
// Ports:
//   req   : per-channel request vector
//   ptr   : index at which the search starts (0..N-1)
//   grant : one-hot grant, all zeros when nothing is requesting
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int  N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic          found;
    logic [PW-1:0] idx;

    // Walk the channels starting at ptr and hand the grant to the first one
    // that is requesting; found stops any later channel from also winning.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// -----------------------------------------------------------------------------
// pixel_write_arbiter
// Shares the VGA adapter's single pixel-write port between several writer
// channels and can take over the port for a full-screen colour fill.
// Ports:
//   clock, resetn           : rising-edge clock, synchronous active-low reset
//   req_valid / req_ready   : per-channel valid/ready handshake
//   req_x/req_y/req_colour  : packed per-channel pixel, channel i at [i*W +: W]
//   clear_start/clear_colour: one-cycle fill request and its colour
//   clear_busy / clear_done : fill in progress / one-cycle completion pulse
//   drop                    : one-cycle pulse when an off-screen pixel is eaten
//   vga_x/vga_y/vga_colour/vga_write : registered write port to the adapter
// -----------------------------------------------------------------------------
module pixel_write_arbiter
    import doom58_pkg::state_t, doom58_pkg::IDLE, doom58_pkg::CLEAR;
#(
    parameter int NUM_CH   = 2,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = doom58_pkg::COLOUR_W,
    parameter int X_MAX    = doom58_pkg::SCREEN_W - 1,
    parameter int Y_MAX    = doom58_pkg::SCREEN_H - 1
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH*X_W-1:0]        req_x,
    input  logic [NUM_CH*Y_W-1:0]        req_y,
    input  logic [NUM_CH*COLOUR_W-1:0]   req_colour,
    input  logic                         clear_start,
    input  logic [COLOUR_W-1:0]          clear_colour,
    output logic                         clear_busy,
    output logic                         clear_done,
    output logic                         drop,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         vga_write
);

    localparam int             PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

    state_t                state;
    logic [PTR_W-1:0]      rr_ptr;
    logic [X_W-1:0]        sweep_x;
    logic [Y_W-1:0]        sweep_y;
    logic [COLOUR_W-1:0]   fill_colour;

    logic [NUM_CH-1:0]     grant;
    logic                  arb_enable;
    logic                  transfer;
    logic                  in_range;
    logic [PTR_W-1:0]      next_ptr;
    logic [X_W-1:0]        sel_x;
    logic [Y_W-1:0]        sel_y;
    logic [COLOUR_W-1:0]   sel_colour;
    logic                  sweep_last;
    logic [X_W-1:0]        next_sweep_x;
    logic [Y_W-1:0]        next_sweep_y;

    rr_arbiter #(
        .N (NUM_CH)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Grants are only exposed while idle and out of reset; a fill request in
    // the same cycle wins, so nobody is granted while the fill is being set up.
    always_comb begin
        arb_enable = resetn && (state == IDLE) && !clear_start;
        req_ready  = arb_enable ? grant : '0;
        transfer   = |(req_valid & req_ready);
    end

    // Pull the granted channel's pixel out of the packed buses and work out
    // where the round-robin pointer goes next (one past the winner).
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        next_ptr   = rr_ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_x      = req_x[i*X_W +: X_W];
                sel_y      = req_y[i*Y_W +: Y_W];
                sel_colour = req_colour[i*COLOUR_W +: COLOUR_W];
                next_ptr   = PTR_W'((i + 1) % NUM_CH);
            end
        end
        in_range = (sel_x <= X_LAST) && (sel_y <= Y_LAST);
    end

    // The sweep counters always hold the pixel currently on the VGA port, so
    // the next raster position is precomputed here: x wraps at the last
    // column and only then does y advance.
    always_comb begin
        sweep_last = (sweep_x == X_LAST) && (sweep_y == Y_LAST);
        if (sweep_x == X_LAST) begin
            next_sweep_x = '0;
            next_sweep_y = sweep_y + Y_W'(1);
        end else begin
            next_sweep_x = sweep_x + X_W'(1);
            next_sweep_y = sweep_y;
        end
    end

    // Main FSM with registered outputs. Pulse outputs default low every
    // cycle. Entering CLEAR already presents pixel (0,0), so the fill emits
    // exactly one pixel per CLEAR cycle and falls back to IDLE right after
    // the last one, raising clear_done in that first idle cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            sweep_x     <= '0;
            sweep_y     <= '0;
            fill_colour <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_write   <= 1'b0;
            clear_busy  <= 1'b0;
            clear_done  <= 1'b0;
            drop        <= 1'b0;
        end else begin
            vga_write  <= 1'b0;
            drop       <= 1'b0;
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state       <= CLEAR;
                        fill_colour <= clear_colour;
                        sweep_x     <= '0;
                        sweep_y     <= '0;
                        vga_x       <= '0;
                        vga_y       <= '0;
                        vga_colour  <= clear_colour;
                        vga_write   <= 1'b1;
                        clear_busy  <= 1'b1;
                    end else if (transfer) begin
                        rr_ptr <= next_ptr;
                        if (in_range) begin
                            vga_x      <= sel_x;
                            vga_y      <= sel_y;
                            vga_colour <= sel_colour;
                            vga_write  <= 1'b1;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (sweep_last) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        sweep_x    <= next_sweep_x;
                        sweep_y    <= next_sweep_y;
                        vga_x      <= next_sweep_x;
                        vga_y      <= next_sweep_y;
                        vga_colour <= fill_colour;
                        vga_write  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
